// File: rtl/ising_pkg.sv
// Shared definitions for the Ising array run sequencer.
//   - run_state_t : sequencer state encoding
//   - OFF_* / SEL_* : register byte offsets and their word selects (addr[3:2])
//   - CTRL_* : bit positions inside the CTRL register
//   - *_RST : reset values of the HOLD_CYC and RUN_CYC registers
package ising_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HOLD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_SAMPLE = 3'd4,
      ST_DONE   = 3'd5
   } run_state_t;

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_HOLD   = 4'h4;
   localparam logic [3:0] OFF_RUN    = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   localparam logic [1:0] SEL_CTRL   = OFF_CTRL[3:2];
   localparam logic [1:0] SEL_HOLD   = OFF_HOLD[3:2];
   localparam logic [1:0] SEL_RUN    = OFF_RUN[3:2];
   localparam logic [1:0] SEL_STATUS = OFF_STATUS[3:2];

   localparam int CTRL_GO    = 0;
   localparam int CTRL_ABORT = 1;

   localparam int HOLD_CYC_RST = 16;
   localparam int RUN_CYC_RST  = 1024;

endpackage

// File: rtl/ising_run_ctrl_if.sv
// Register bus shared by the run sequencer and the array cells.
//   wready  : one-cycle write strobe
//   wr_addr : write byte offset, [3:2] selects the register
//   wdata   : write data
//   rd_addr : read byte offset, [3:2] selects the register
//   rdata   : combinational read data
// master = register decode side (drives writes/read address), slave = this block.
interface ising_run_ctrl_if;
   logic        wready;
   logic [3:0]  wr_addr;
   logic [31:0] wdata;
   logic [3:0]  rd_addr;
   logic [31:0] rdata;

   modport master (output wready, output wr_addr, output wdata, output rd_addr, input rdata);
   modport slave  (input wready, input wr_addr, input wdata, input rd_addr, output rdata);
endinterface

// File: rtl/ising_run_regs.sv
// Register file of the run sequencer: HOLD_CYC / RUN_CYC storage, CTRL decode
// into registered GO/ABORT requests, and combinational read mux.
// Ports:
//   clk, axi_rstn          : clock, async active-low reset
//   bus (slave)            : register write/read bus
//   busy, done, aborted    : status inputs from the sequencer
//   hold_cyc, run_cyc      : programmed lengths
//   go_req, abort_req      : one-cycle requests, registered on the write edge
// Optional feature macro: ISING_RUN_ABORT_EN enables decoding of CTRL.ABORT.
module ising_run_regs
   import ising_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             axi_rstn,
   ising_run_ctrl_if.slave  bus,
   input  logic             busy,
   input  logic             done,
   input  logic             aborted,
   output logic [CNT_W-1:0] hold_cyc,
   output logic [CNT_W-1:0] run_cyc,
   output logic             go_req,
   output logic             abort_req
);

   logic wr_ctrl, wr_hold, wr_run;
   logic go_wr, abort_wr;
   logic unused_bits;

   assign wr_ctrl = bus.wready && (bus.wr_addr[3:2] == SEL_CTRL);
   assign wr_hold = bus.wready && (bus.wr_addr[3:2] == SEL_HOLD) && !busy;
   assign wr_run  = bus.wready && (bus.wr_addr[3:2] == SEL_RUN)  && !busy;

`ifdef ISING_RUN_ABORT_EN
   assign abort_wr = wr_ctrl && bus.wdata[CTRL_ABORT];
`else
   assign abort_wr = 1'b0;
`endif

   // ABORT wins when both bits are written together.
   assign go_wr = wr_ctrl && bus.wdata[CTRL_GO] && !busy && !abort_wr;

   assign unused_bits = ^{bus.wr_addr[1:0], bus.rd_addr[1:0], bus.wdata[31:CNT_W]};

   always_ff @(posedge clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         hold_cyc  <= CNT_W'(HOLD_CYC_RST);
         run_cyc   <= CNT_W'(RUN_CYC_RST);
         go_req    <= 1'b0;
         abort_req <= 1'b0;
      end else begin
         go_req    <= go_wr;
         abort_req <= abort_wr;
         if (wr_hold) hold_cyc <= bus.wdata[CNT_W-1:0];
         if (wr_run)  run_cyc  <= bus.wdata[CNT_W-1:0];
      end
   end

   always_comb begin
      bus.rdata = '0;
      case (bus.rd_addr[3:2])
         SEL_HOLD:   bus.rdata = 32'(hold_cyc);
         SEL_RUN:    bus.rdata = 32'(run_cyc);
         SEL_STATUS: bus.rdata = {29'd0, aborted, done, busy};
         default:    bus.rdata = '0;
      endcase
   end

endmodule

// File: rtl/ising_run_ctrl.sv
// Anneal-run sequencer for the ring-oscillator Ising array. Drives the
// array-wide ising_rstn/start nets and a one-cycle sample pulse at run end.
// Ports:
//   clk, axi_rstn : clock, async active-low reset
//   bus (slave)   : register write/read bus (CTRL, HOLD_CYC, RUN_CYC, STATUS)
//   ising_rstn    : 0 holds all cell latches cleared
//   start         : 1 closes the oscillator loops
//   sample        : one-cycle phase-capture pulse, last cycle of start=1
//   busy, done    : run in progress / run finished
// Optional feature macro: ISING_RUN_ABORT_EN enables CTRL.ABORT.
//
// state  | meaning
// IDLE   | latches cleared, loops open, waiting for GO
// HOLD   | latches cleared for max(HOLD_CYC,1) cycles
// SETTLE | latches released, cells drive programmed spin, SETTLE_CYCLES cycles
// RUN    | oscillators coupled for max(RUN_CYC,1) cycles
// SAMPLE | final coupled cycle, sample pulse issued
// DONE   | run finished, latches hold result, GO restarts at HOLD
module ising_run_ctrl
   import ising_pkg::*;
#(
   parameter int CNT_W         = 24,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            axi_rstn,
   ising_run_ctrl_if.slave bus,
   output logic            ising_rstn,
   output logic            start,
   output logic            sample,
   output logic            busy,
   output logic            done
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   run_state_t       state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [CNT_W-1:0] hold_cyc, run_cyc, hold_load, run_load;
   logic             aborted_q, aborted_nxt;
   logic             go_req, abort_req;
   logic             rstn_nxt, start_nxt, sample_nxt, busy_nxt, done_nxt;

   ising_run_regs #(.CNT_W(CNT_W)) u_regs (
      .clk       (clk),
      .axi_rstn  (axi_rstn),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted_q),
      .hold_cyc  (hold_cyc),
      .run_cyc   (run_cyc),
      .go_req    (go_req),
      .abort_req (abort_req)
   );

   // A programmed length of 0 behaves as 1; the counter holds length-1.
   assign hold_load = (hold_cyc == '0) ? '0 : hold_cyc - CNT_W'(1);
   assign run_load  = (run_cyc  == '0) ? '0 : run_cyc  - CNT_W'(1);

   always_ff @(posedge clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         aborted_q  <= 1'b0;
         ising_rstn <= 1'b0;
         start      <= 1'b0;
         sample     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         cnt_q      <= cnt_nxt;
         aborted_q  <= aborted_nxt;
         ising_rstn <= rstn_nxt;
         start      <= start_nxt;
         sample     <= sample_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state_q;
      cnt_nxt     = cnt_q;
      aborted_nxt = aborted_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (go_req) begin
               state_nxt   = ST_HOLD;
               cnt_nxt     = hold_load;
               aborted_nxt = 1'b0;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_nxt = ST_SETTLE;
               cnt_nxt   = SETTLE_LOAD;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_nxt = ST_RUN;
               cnt_nxt   = run_load;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (cnt_q == '0) begin
               state_nxt = ST_SAMPLE;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_SAMPLE: state_nxt = ST_DONE;
         default:   state_nxt = ST_IDLE;
      endcase

`ifdef ISING_RUN_ABORT_EN
      // Abort overrides the normal transition, so a pending SAMPLE is never entered.
      if (abort_req && (state_q != ST_IDLE)) begin
         state_nxt   = ST_IDLE;
         cnt_nxt     = '0;
         aborted_nxt = 1'b1;
      end
`endif
   end

`ifndef ISING_RUN_ABORT_EN
   logic unused_abort;
   assign unused_abort = abort_req;
`endif

   // Outputs are registered from the next state so they change with the state.
   always_comb begin
      rstn_nxt   = 1'b0;
      start_nxt  = 1'b0;
      sample_nxt = 1'b0;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      case (state_nxt)
         ST_HOLD:   busy_nxt = 1'b1;
         ST_SETTLE: begin
            rstn_nxt = 1'b1;
            busy_nxt = 1'b1;
         end
         ST_RUN: begin
            rstn_nxt  = 1'b1;
            start_nxt = 1'b1;
            busy_nxt  = 1'b1;
         end
         ST_SAMPLE: begin
            rstn_nxt   = 1'b1;
            start_nxt  = 1'b1;
            sample_nxt = 1'b1;
            busy_nxt   = 1'b1;
         end
         ST_DONE: begin
            rstn_nxt = 1'b1;
            done_nxt = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/ising_run_ctrl.md
# ising_run_ctrl

Sequencer for one anneal run of the ring-oscillator Ising array. It drives the array-wide `ising_rstn` and `start` nets that every coupled/shorted cell consumes, and issues a one-cycle `sample` pulse for the phase-capture logic at the end of the run. It is programmed over the same synchronous register write interface the cells use for spin loading, and sits between the AXI register decode and the array top.

## Interface
- `CNT_W`, 24: width of the hold and run cycle counters/registers.
- `SETTLE_CYCLES`, 4: fixed cycles between `ising_rstn` release and `start` assertion; minimum 1.
- `clk` in 1: system/AXI clock.
- `axi_rstn` in 1: asynchronous, active-low reset.
- `wready` in 1: write strobe, one cycle per write.
- `wr_addr` in 4: byte offset of the write; bits [3:2] select the register.
- `wdata` in 32: write data.
- `rd_addr` in 4: byte offset of the read; bits [3:2] select the register.
- `rdata` out 32: combinational read data for `rd_addr`.
- `ising_rstn` out 1: array latch enable; 0 holds all cell latches cleared.
- `start` out 1: 1 closes the oscillator loops; 0 makes cells drive their programmed spin.
- `sample` out 1: one-cycle capture pulse for the phase sampler.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.

## Operation
- Registers:
  - 0x0 CTRL (W): bit0 GO, bit1 ABORT.
  - 0x4 HOLD_CYC (R/W): `CNT_W` bits.
  - 0x8 RUN_CYC (R/W): `CNT_W` bits.
  - 0xC STATUS (R): bit0 busy, bit1 done, bit2 aborted.
  - CTRL reads as 0. Unused upper bits read 0.
  - Reset values: HOLD_CYC=16, RUN_CYC=1024.
- States: IDLE, HOLD, SETTLE, RUN, SAMPLE, DONE.
  - IDLE: `ising_rstn`=0, `start`=0. GO moves to HOLD.
  - HOLD: `ising_rstn`=0, `start`=0 for max(HOLD_CYC,1) cycles, then SETTLE.
  - SETTLE: `ising_rstn`=1, `start`=0 for `SETTLE_CYCLES` cycles, then RUN.
  - RUN: `ising_rstn`=1, `start`=1 for max(RUN_CYC,1) cycles, then SAMPLE.
  - SAMPLE: `ising_rstn`=1, `start`=1, `sample`=1 for exactly one cycle, then DONE.
  - DONE: `ising_rstn`=1, `start`=0, `done`=1. GO moves to HOLD directly.
- One down-counter of `CNT_W` bits is shared across HOLD, SETTLE and RUN. It is loaded on state entry with length−1 and the state exits when the counter reads 0.
- Writes to HOLD_CYC or RUN_CYC while `busy` are ignored. GO while `busy` is ignored.
- A write with GO and ABORT both set applies ABORT only.
- Aborted flag: cleared by an accepted GO.
- Reset values of outputs: `ising_rstn`=0, `start`=0, `sample`=0, `busy`=0, `done`=0. State is IDLE.

## Timing
- All outputs are registered, with no combinational path from write inputs to outputs.
- A GO write accepted at edge t makes `ising_rstn`=0 and `busy`=1 visible after edge t+1. HOLD lasts HOLD_CYC cycles. SETTLE lasts `SETTLE_CYCLES` cycles.
- Total cycles from HOLD entry to DONE entry: HOLD_CYC + `SETTLE_CYCLES` + RUN_CYC + 1.
- `sample` is high for the final cycle of `start`=1. `start` falls on the same edge that raises `done`.
- Asynchronous reset mid-run: all outputs are forced to reset values immediately, registers return to their reset values, and no `sample` pulse is issued.

## Configuration
- `ISING_RUN_ABORT_EN` defined: ABORT is accepted in any state other than IDLE. On the next edge the block enters IDLE with IDLE outputs, sets the aborted flag, and suppresses `sample`.
- `ISING_RUN_ABORT_EN` undefined: the ABORT bit is ignored and STATUS bit2 reads 0.

## Structure
- Shared package `ising_pkg`:
  - state encoding enum.
  - register offsets CTRL/HOLD/RUN/STATUS.
  - CTRL bit positions.
  - HOLD_CYC and RUN_CYC reset values.
- Natural sub-module: `ising_run_regs`, the register write/read decode with busy-gating. The FSM and counter stay in the top module.

## Test plan
- Reset, then write HOLD_CYC=3, RUN_CYC=5, then GO -> `ising_rstn` low 3 cycles, high with `start`=0 for 4 cycles, `start` high 6 cycles with `sample` on the 6th, then `done`=1.
- HOLD_CYC=0, RUN_CYC=0, GO -> each treated as 1; DONE reached 1+4+1+1=7 cycles after HOLD entry.
- During RUN, write RUN_CYC=99 and GO -> both ignored; run completes with the original length and RUN_CYC still reads the old value.
- From DONE, GO -> HOLD entered next cycle, `done` drops and `busy` rises on the same edge.
- With `ISING_RUN_ABORT_EN`, ABORT in RUN cycle 2 -> IDLE next edge, `start`=0, no `sample`, STATUS=0x4. A following GO clears bit2.
- Deassert `axi_rstn` in SETTLE -> outputs go to 0 immediately, and HOLD_CYC and RUN_CYC read 16 and 1024 after release.
